// File: rtl/banco_pkg.sv
// banco_pkg: shared state type and default sizes for the register bank
package banco_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF = 32;
endpackage

// File: rtl/banco_registro_param_if.sv
// banco_registro_param_if: read/write/clear bus of the register bank
interface banco_registro_param_if import banco_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic clr_req;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic enesc;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic busy;
  modport master(output clr_req, ReadReg1, ReadReg2, WriteRegister, WriteData, enesc,
                 input ReadData1, ReadData2, busy);
  modport slave(input clr_req, ReadReg1, ReadReg2, WriteRegister, WriteData, enesc,
                output ReadData1, ReadData2, busy);
endinterface

// File: rtl/banco_registro_param_clear_seq.sv
// clear_seq: zeroes one register per cycle after reset or on request
module clear_seq import banco_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr_req,
  output logic o_busy,
  output logic o_ov_en,
  output logic [ADDR_W-1:0] o_ov_addr,
  output logic [DATA_W-1:0] o_ov_data
);
  state_t r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  // walk clr_idx over every register, then hand over to RUN; clr_req only starts from RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_clr_idx <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == ADDR_W'(NREGS - 1)) r_state <= RUN;
    end else if (i_clr_req) begin
      r_state <= CLEAR;
      r_clr_idx <= '0;
    end
  end
  assign o_busy = r_state == CLEAR;
  assign o_ov_en = o_busy && !rst;
  assign o_ov_addr = r_clr_idx;
  assign o_ov_data = '0;
endmodule

// File: rtl/banco_registro_param.sv
// banco_registro_param: 2R/1W register bank with zero register, bypass and clear sequencer
module banco_registro_param import banco_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  banco_registro_param_if.slave bus
);
  localparam int NSLOT = 2 ** ADDR_W;
  logic w_busy;
  logic w_ov_en;
  logic [ADDR_W-1:0] w_ov_addr;
  logic [DATA_W-1:0] w_ov_data;
  logic w_wr_ok;
  logic [DATA_W-1:0] w_br [NSLOT];

  clear_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_clear_seq (
    .clk(clk),
    .rst(rst),
    .i_clr_req(bus.clr_req),
    .o_busy(w_busy),
    .o_ov_en(w_ov_en),
    .o_ov_addr(w_ov_addr),
    .o_ov_data(w_ov_data)
  );

  assign w_wr_ok = bus.enesc && !w_busy && int'(bus.WriteRegister) < NREGS
                   && !(ZERO_REG != 0 && bus.WriteRegister == '0);

  // address slots beyond NREGS read as constant zero so the read mux never sees X
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NREGS) begin : g_reg
      logic [DATA_W-1:0] r_q;
      // the clear sequencer's zero write takes priority over the normal write path
      always_ff @(posedge clk) begin
        if (w_ov_en && w_ov_addr == ADDR_W'(g)) r_q <= w_ov_data;
        else if (w_wr_ok && bus.WriteRegister == ADDR_W'(g)) r_q <= bus.WriteData;
      end
      assign w_br[g] = r_q;
    end else begin : g_nil
      assign w_br[g] = '0;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] q,
    input logic busy,
    input logic wr_ok,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    return busy ? '0 :
           int'(a) >= NREGS ? '0 :
           (ZERO_REG != 0 && a == '0) ? '0 :
           (BYPASS != 0 && wr_ok && wa == a) ? wd : q;
  endfunction

  assign bus.ReadData1 = rd_port(bus.ReadReg1, w_br[bus.ReadReg1], w_busy, w_wr_ok,
                                 bus.WriteRegister, bus.WriteData);
  assign bus.ReadData2 = rd_port(bus.ReadReg2, w_br[bus.ReadReg2], w_busy, w_wr_ok,
                                 bus.WriteRegister, bus.WriteData);
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_banco_registro_param.sv
// tb_banco_registro_param: two bank configurations checked against a behavioural model
module tb_banco_registro_param;
  logic clk = 0;
  logic rst = 1;
  logic clr_req = 0;
  logic en = 0;
  logic [4:0] rr1 = 0;
  logic [4:0] rr2 = 0;
  logic [4:0] wa = 0;
  logic [31:0] wd = 0;
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;
  int ca, cb, n;

  always #5 clk = ~clk;

  banco_registro_param_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  banco_registro_param_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
  assign ifa.clr_req = clr_req;
  assign ifa.ReadReg1 = rr1;
  assign ifa.ReadReg2 = rr2;
  assign ifa.WriteRegister = wa;
  assign ifa.WriteData = wd;
  assign ifa.enesc = en;
  assign ifb.clr_req = clr_req;
  assign ifb.ReadReg1 = rr1;
  assign ifb.ReadReg2 = rr2;
  assign ifb.WriteRegister = wa;
  assign ifb.WriteData = wd;
  assign ifb.enesc = en;

  banco_registro_param #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  banco_registro_param #(.DATA_W(32), .ADDR_W(5), .NREGS(16), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  // model: index 0 = 32 regs, zero reg, bypass; index 1 = 16 regs, no zero reg, no bypass
  logic [31:0] mem [2][32];
  int rem [2];

  function automatic int nr(int d);
    return d == 0 ? 32 : 16;
  endfunction

  function automatic bit legal(int d);
    return en && rem[d] == 0 && int'(wa) < nr(d) && !(d == 0 && wa == 0);
  endfunction

  function automatic logic [31:0] expect_rd(int d, logic [4:0] a);
    if (rem[d] > 0 || int'(a) >= nr(d) || (d == 0 && a == 0)) return 0;
    if (d == 0 && legal(d) && wa == a) return wd;
    return mem[d][a];
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model update on every edge, from the inputs held through the previous cycle
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rem[d] = nr(d);
        for (int k = 0; k < 32; k++) mem[d][k] = 0;
      end else if (rem[d] > 0) begin
        rem[d]--;
      end else begin
        if (legal(d)) mem[d][wa] = wd;
        if (clr_req) begin
          rem[d] = nr(d);
          for (int k = 0; k < 32; k++) mem[d][k] = 0;
        end
      end
    end
  end

  // continuous comparison of both banks against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_a", 32'(ifa.busy), 32'(rem[0] > 0));
      check("busy_b", 32'(ifb.busy), 32'(rem[1] > 0));
      check("rd1_a", ifa.ReadData1, expect_rd(0, rr1));
      check("rd2_a", ifa.ReadData2, expect_rd(0, rr2));
      check("rd1_b", ifb.ReadData1, expect_rd(1, rr1));
      check("rd2_b", ifb.ReadData2, expect_rd(1, rr2));
    end
  end

  task automatic count_busy();
    ca = 0;
    cb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ca += int'(ifa.busy);
      cb += int'(ifb.busy);
      step();
      en = 0;
    end
  endtask

  initial begin
    rst = 1;
    step();
    chk_en = 1;
    step();
    rst = 0;
    count_busy();
    check("init_busy_len_a", ca, 32);
    check("init_busy_len_b", cb, 16);
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a);
      rr2 = 5'(31 - a);
      @(negedge clk);
      check("init_zero_a", ifa.ReadData1, 0);
      step();
    end
    en = 1; wa = 5; wd = 32'hDEADBEEF; rr1 = 5;
    @(negedge clk);
    check("bypass_a", ifa.ReadData1, 32'hDEADBEEF);
    check("nobypass_b", ifb.ReadData1, 0);
    step();
    en = 0;
    @(negedge clk);
    check("stored_a", ifa.ReadData1, 32'hDEADBEEF);
    check("stored_b", ifb.ReadData1, 32'hDEADBEEF);
    step();
    en = 1; wa = 0; wd = 32'h12345678; rr1 = 0; rr2 = 0;
    @(negedge clk);
    check("zreg_byp1_a", ifa.ReadData1, 0);
    check("zreg_byp2_a", ifa.ReadData2, 0);
    step();
    en = 0;
    @(negedge clk);
    check("zreg1_a", ifa.ReadData1, 0);
    check("zreg2_a", ifa.ReadData2, 0);
    check("reg0_b", ifb.ReadData1, 32'h12345678);
    step();
    en = 1; wa = 7; wd = 32'hA5A5A5A5;
    step();
    en = 0; clr_req = 1;
    @(negedge clk);
    check("pre_clr_busy_a", 32'(ifa.busy), 0);
    step();
    clr_req = 0; en = 1; wa = 9; wd = 32'h99999999;
    count_busy();
    check("clr_busy_len_a", ca, 32);
    check("clr_busy_len_b", cb, 16);
    rr1 = 7; rr2 = 9;
    @(negedge clk);
    check("cleared7_a", ifa.ReadData1, 0);
    check("dropped9_a", ifa.ReadData2, 0);
    check("cleared7_b", ifb.ReadData1, 0);
    step();
    clr_req = 1;
    step();
    clr_req = 1;
    repeat (10) step();
    clr_req = 0;
    rst = 1;
    step();
    rst = 0;
    count_busy();
    check("rst_busy_len_a", ca, 32);
    check("rst_busy_len_b", cb, 16);
    en = 1; wa = 20; wd = 32'hCAFEF00D;
    step();
    wa = 15; wd = 32'h0000FFFF;
    step();
    en = 0; rr1 = 20; rr2 = 15;
    @(negedge clk);
    check("oor20_b", ifb.ReadData1, 0);
    check("reg15_b", ifb.ReadData2, 32'h0000FFFF);
    check("reg20_a", ifa.ReadData1, 32'hCAFEF00D);
    step();
    n = 0;
    repeat (500) begin
      rst = $urandom_range(0, 199) == 0;
      clr_req = $urandom_range(0, 63) == 0;
      en = $urandom_range(0, 1) == 1;
      wa = 5'($urandom);
      wd = $urandom;
      rr1 = $urandom_range(0, 3) == 0 ? wa : 5'($urandom);
      rr2 = $urandom_range(0, 3) == 0 ? wa : 5'($urandom);
      step();
      n++;
    end
    rst = 0; clr_req = 0; en = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/banco_registro_param.md
Name: banco_registro_param

Overview:
Parametrised, clocked successor to the datapath register bank. It provides two asynchronous read ports and one synchronous write port. Optional features are a hardwired zero register and write-to-read bypass. A built-in clear sequencer zeroes every register after reset, or on request, one register per cycle, and reports busy while it runs. It sits in the DataPath between instruction decode (register addresses) and the ALU/writeback mux.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NREGS, 32, number of registers (2..2**ADDR_W)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read port

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous, active-high reset
clr_req  in  1  pulse to start a full clear sequence
ReadReg1  in  ADDR_W  read address, port 1
ReadReg2  in  ADDR_W  read address, port 2
WriteRegister  in  ADDR_W  write address
WriteData  in  DATA_W  write data
enesc  in  1  write enable
ReadData1  out  DATA_W  read data, port 1 (combinational)
ReadData2  out  DATA_W  read data, port 2 (combinational)
busy  out  1  clear sequence in progress; writes ignored

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- FSM states: CLEAR and RUN.
- Reset: state <= CLEAR and clr_idx <= 0. busy = 1 from the first edge with rst high.
- Register contents are not touched by rst itself; the sequencer zeroes them.
- CLEAR: each cycle writes BR[clr_idx] <= 0 and increments clr_idx.
  - When clr_idx == NREGS-1 the last register is zeroed and state <= RUN.
  - busy is high for exactly NREGS cycles after rst deasserts.
- RUN + clr_req: state <= CLEAR, clr_idx <= 0. busy rises on the next cycle.
- clr_req while in CLEAR: ignored; the sequence is not restarted.
- rst during CLEAR: restarts the sequence at index 0.
- Write: on a rising edge in RUN, if enesc=1, WriteRegister < NREGS, and not (ZERO_REG and WriteRegister==0), then BR[WriteRegister] <= WriteData.
  - Writes with enesc=1 during CLEAR are dropped, not queued.
- Read: ReadDataN = BR[ReadRegN], combinational, zero latency.
- Read overrides, in priority order:
  1. busy=1 -> 0.
  2. ReadRegN >= NREGS -> 0.
  3. ZERO_REG and ReadRegN==0 -> 0.
  4. BYPASS and enesc and WriteRegister==ReadRegN and the write is legal -> WriteData (write-first).
  5. Otherwise the stored value.
- With BYPASS=0, the new value becomes visible on the cycle after the write edge.
- Both read ports may address the same register; both return the identical value.
- No other state. No X on outputs after the clear completes.

Decomposition:
- Shared package banco_pkg holds:
  - the state typedef (CLEAR, RUN);
  - default constants DATA_W_DEF=32, ADDR_W_DEF=5, NREGS_DEF=32.
- One sub-module is natural: clear_seq, holding the FSM, clr_idx counter and busy output. It presents a write-override port (address, zero data, enable) that muxes ahead of the normal write path.
- Read-override logic stays in the top level. Both ports instantiate the same function.

Test Plan:
1. rst=1 for 2 cycles, then 0 (NREGS=32) -> busy=1 for exactly 32 cycles, then 0. ReadReg1=0..31 all read 0x00000000 afterwards.
2. Write enesc=1, WriteRegister=5, WriteData=0xDEADBEEF; ReadReg1=5 in the same cycle.
   - BYPASS=1: ReadData1=0xDEADBEEF in that cycle.
   - BYPASS=0: 0 in that cycle, 0xDEADBEEF the next.
3. ZERO_REG=1: write 0x12345678 to register 0 -> ReadData1 and ReadData2 at address 0 stay 0, including the same-cycle bypass case.
4. Write 0xA5A5A5A5 to register 7, then pulse clr_req.
   - busy rises next cycle; a write to register 9 issued during busy is dropped.
   - After 32 cycles: register 7 = 0, register 9 = 0.
5. rst asserted at clear cycle 10 -> clr_idx restarts. busy stays high 32 more cycles after rst deasserts.
6. NREGS=16, ADDR_W=5: write to register 20 is ignored. Reading register 20 returns 0. Register 15 is written and read back normally (e.g. 0x0000FFFF).
